fc_rx_frame_checker: RTL and testbench
======================================

# fc_rx_frame_checker

Receive-side frame checker sitting directly downstream of the FC framer's user RX stream. It strips the SOF and EOF ordered-set words and drops the trailing CRC word. It checks the FC CRC-32 and the frame length, and flags EOFa aborts and truncated frames. It delivers header+payload words as a clean Avalon-ST packet with a per-frame error vector and keeps management-readable frame statistics.

## Interface
- MIN_WORDS, 7: minimum words between SOF and EOF (6 header + CRC).
- MAX_WORDS, 535: maximum words between SOF and EOF (6 header + 528 payload + CRC).
- clk  in  1  block clock, same domain as the framer rx_clk.
- reset_n  in  1  reset, asynchronous, active-low.
- in_data  in  32  framer userrx data; SOF/EOF words carry the primitive.
- in_valid  in  1  word qualifier; no backpressure exists.
- in_startofpacket  in  1  SOF word marker.
- in_endofpacket  in  1  EOF word marker (both high = lone primitive).
- out_data  out  32  header/payload word.
- out_valid  out  1  word qualifier.
- out_startofpacket  out  1  first header word.
- out_endofpacket  out  1  last payload word.
- out_empty  out  2  constant 0.
- out_error  out  3  valid with eop: [0] CRC mismatch, [1] length, [2] abort/truncated.
- mm_address  in  3  statistics register select.
- mm_read  in  1  read strobe.
- mm_readdata  out  32  registered read data.

## Operation
- States: OUT_OF_FRAME, IN_FRAME. A word is accepted only when in_valid=1.
- Lone primitive (sop=eop=1) is ignored in both states.
- OUT_OF_FRAME + sop: go IN_FRAME; clear CRC (0xFFFFFFFF), word count, hold buffer, and abort flag. The SOF word is not forwarded.
- OUT_OF_FRAME + other words: discarded.
- IN_FRAME data word:
  - Increment the count, saturating at MAX_WORDS+1.
  - Feed the word to the CRC.
  - Push it into a 2-entry hold buffer (h1 older, h0 newer).
  - When the buffer is already full, emit h1 first. Its sop is set if it is the frame's first emitted word.
- CRC rules:
  - Reflected CRC-32, poly 0x04C11DB7, preset 0xFFFFFFFF.
  - Bytes are fed in_data[31:24] first.
  - The CRC register is updated on every data word except the one that ends up as CRC. A shadow "CRC before h0" is kept for the check.
  - The check passes when h0 equals ~shadow.
- IN_FRAME + eop:
  - Decode with fc::map_primitive. fc::PRIM_EOFA sets abort.
  - When count ≥ 2: emit h1 with eop, drop h0 (the CRC word), and go OUT_OF_FRAME.
  - When count < 2: emit nothing, count the frame as a length error, and go OUT_OF_FRAME.
- IN_FRAME + sop (missing EOF): treat as truncation.
  - Close the current frame exactly as eop would, with abort set and error[0] forced 0.
  - Then open the new frame from this SOF.
- Error vector:
  - [1] set when count < MIN_WORDS or count > MAX_WORDS.
  - [2] set on EOFa or truncation.
  - [0] set on CRC mismatch.
- Statistics: each closed frame increments exactly one 32-bit wrapping counter, by priority abort > length > CRC > good.
- Register map:
  - 0 good
  - 1 crc_err
  - 2 len_err
  - 3 aborted
  - 4 current state (0/1)
  - other addresses return 0xFFFFFFFF.
- Counters are not cleared by reads.

## Timing
- Reset: all outputs and counters are 0, state is OUT_OF_FRAME, and the hold buffer is empty.
- Outputs are registered. The word emitted due to an accepted input appears on out_* the following cycle with out_valid=1 for one cycle.
- out_valid is 0 in every other cycle, and out_error is 0 whenever out_endofpacket=0.
- Latency: a data word leaves 1 cycle after the second-following data word is accepted. The final payload word leaves 1 cycle after EOF is accepted.
- in_valid gaps stall the pipeline with no loss; held words persist.
- Truncation closing and the new SOF in the same cycle yield at most one output word (the old h1).
- mm_readdata updates 1 cycle after mm_read and holds otherwise. A counter increment and a read in the same cycle return the pre-increment value.
- Reset asserted mid-frame aborts silently: no output and no counter increment.

## Configuration
- FC_RX_FRAME_CHECK_CRC_EN defined: CRC engine compiled in and error[0] as specified.
- Undefined: CRC logic is removed. The CRC word is still dropped, error[0] is tied 0, and the crc_err register reads 0.

## Structure
- fc package additions:
  - FC_CRC32_POLY and FC_CRC32_PRESET constants.
  - error bit index constants.
  - rx_check_state_t enum.
  - statistics register address constants.
- Sub-module fc_crc32_word: purely combinational 32-bit-per-cycle CRC update (crc_in, data → crc_out), reusable by the future TX frame builder.

## Test plan
- Good frame:
  - Stimulus: SOFi3, 6 header words, 4 payload words 0x00010203..0x0C0D0E0F, correct CRC from the bench model, EOFn.
  - Response: 10 output words, sop on the first and eop on the last, out_error=0, reg0=1.
- CRC corruption:
  - Stimulus: same frame with CRC bit 0 flipped.
  - Response: eop with out_error=3'b001, reg1=1.
- Length errors:
  - Frame of SOF, 3 words, CRC, EOF: 3 words out, eop error=3'b010.
  - Frame of SOF, 1 word, EOF: nothing emitted, reg2=1.
- Abort and truncation:
  - Good frame ended with EOFa: error=3'b100, reg3=1.
  - Frame interrupted by a second SOF: first frame closed with error=3'b100, and the second frame passes clean.
- Gaps and reset:
  - Insert random 0–3 cycle in_valid gaps throughout a good frame: output is identical.
  - Assert reset_n low mid-frame: out_valid=0 and all counters read 0 afterward.

Source files
------------

// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg.sv -- shared Fibre Channel definitions (package fc).
//
// Purpose : ordered-set decoding, FC CRC-32 constants and per-byte update
//           helper, RX frame checker error-bit indices, state encoding and
//           statistics register addresses.
// Ports   : none (package).
// Config  : FC_RX_FRAME_CHECK_CRC_EN is consumed by the users of this package.
// -----------------------------------------------------------------------------
package fc;

  // FC CRC-32: normal-form polynomial, its bit-reflected form used by the
  // LSB-first shift, and the register preset.
  localparam logic [31:0] FC_CRC32_POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] FC_CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] FC_CRC32_PRESET    = 32'hFFFF_FFFF;

  // Bit positions inside the RX checker per-frame error vector.
  localparam int ERR_CRC   = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_ABORT = 2;

  typedef enum logic [0:0] {
    RX_OUT_OF_FRAME = 1'b0,
    RX_IN_FRAME     = 1'b1
  } rx_check_state_t;

  // Statistics register map of the RX checker.
  localparam logic [2:0] STAT_ADDR_GOOD    = 3'd0;
  localparam logic [2:0] STAT_ADDR_CRC_ERR = 3'd1;
  localparam logic [2:0] STAT_ADDR_LEN_ERR = 3'd2;
  localparam logic [2:0] STAT_ADDR_ABORTED = 3'd3;
  localparam logic [2:0] STAT_ADDR_STATE   = 3'd4;

  typedef enum logic [2:0] {
    PRIM_NONE,
    PRIM_SOFI3,
    PRIM_SOFN3,
    PRIM_EOFN,
    PRIM_EOFT,
    PRIM_EOFA
  } prim_t;

  // Ordered sets start with K28.5 (0xBC). Byte 2 of an EOF changes with the
  // running disparity, so only bytes 3, 1 and 0 identify the primitive.
  function automatic prim_t map_primitive(input logic [31:0] w);
    prim_t p;
    p = PRIM_NONE;
    if (w[31:24] == 8'hBC) begin
      case (w[15:0])
        16'h5656: p = PRIM_SOFI3;
        16'h3636: p = PRIM_SOFN3;
        16'hD5D5: p = PRIM_EOFN;
        16'h7575: p = PRIM_EOFT;
        16'hF5F5: p = PRIM_EOFA;
        default:  p = PRIM_NONE;
      endcase
    end
    return p;
  endfunction

  // One byte of reflected CRC-32, byte bits consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ FC_CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/fc_crc32_word.sv
// -----------------------------------------------------------------------------
// fc_crc32_word.sv -- combinational FC CRC-32 update for one 32-bit word.
//
// Ports   : crc_in  [31:0] running CRC register value
//           data    [31:0] word to absorb, byte [31:24] first
//           crc_out [31:0] updated CRC
// -----------------------------------------------------------------------------
module fc_crc32_word
  import fc::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int b = 3; b >= 0; b--) begin
      crc_out = crc32_byte(crc_out, data[b*8 +: 8]);
    end
  end

endmodule

// File: rtl/fc_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// fc_rx_frame_checker.sv -- FC receive frame checker.
//
// Strips SOF/EOF, drops the trailing CRC word, checks CRC-32 and length,
// flags EOFa / truncated frames, and streams header+payload as an Avalon-ST
// packet with an error vector on the end-of-packet beat. Keeps four wrapping
// frame counters readable over a small register port.
//
// Ports   : clk, reset_n (async, active-low)
//           in_data/in_valid/in_startofpacket/in_endofpacket  framer RX stream
//           out_data/out_valid/out_startofpacket/out_endofpacket/out_empty/
//           out_error                                         checked packet
//           mm_address/mm_read/mm_readdata                    statistics
// Config  : FC_RX_FRAME_CHECK_CRC_EN -- when defined the CRC engine is built;
//           otherwise error[0] is 0 and the crc_err register reads 0.
// -----------------------------------------------------------------------------
module fc_rx_frame_checker
  import fc::*;
#(
  parameter int MIN_WORDS = 7,
  parameter int MAX_WORDS = 535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty,
  output logic [2:0]  out_error,
  input  logic [2:0]  mm_address,
  input  logic        mm_read,
  output logic [31:0] mm_readdata
);

  localparam int CNT_W = $clog2(MAX_WORDS + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);
  localparam logic [0:0] S_OUT_OF_FRAME = 1'(RX_OUT_OF_FRAME);
  localparam logic [0:0] S_IN_FRAME     = 1'(RX_IN_FRAME);

  logic [0:0]       state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [31:0]      h1_reg, h0_reg;
  logic [1:0]       fill_reg;
  logic             emitted_reg;
  logic [31:0]      out_data_reg;
  logic             out_valid_reg, out_sop_reg, out_eop_reg;
  logic [2:0]       out_error_reg;
  logic [31:0]      good_cnt_reg, len_cnt_reg, abort_cnt_reg, readdata_reg;

  logic sof_word, eof_word, data_word, in_frame;
  logic data_accept, close_frame, truncate, abort_now;
  logic short_frame, len_bad, crc_bad;
  logic [2:0] err_vec;

  // Lone primitives (sop and eop together) fall into none of these classes.
  assign sof_word  = in_valid &  in_startofpacket & ~in_endofpacket;
  assign eof_word  = in_valid & ~in_startofpacket &  in_endofpacket;
  assign data_word = in_valid & ~in_startofpacket & ~in_endofpacket;
  assign in_frame  = (state_reg == S_IN_FRAME);

  assign data_accept = in_frame & data_word;
  assign truncate    = in_frame & sof_word;
  assign close_frame = in_frame & (eof_word | sof_word);
  assign abort_now   = truncate | (eof_word & (map_primitive(in_data) == PRIM_EOFA));
  assign short_frame = (count_reg < CNT_W'(2));
  assign len_bad     = (count_reg < CNT_MIN) | (count_reg > CNT_MAX);

`ifdef FC_RX_FRAME_CHECK_CRC_EN
  logic [31:0] crc_reg, shadow_reg, crc_next, crc_cnt_reg;

  fc_crc32_word u_crc (
    .crc_in  (crc_reg),
    .data    (in_data),
    .crc_out (crc_next)
  );

  // shadow_reg is the CRC over everything except h0, so when the frame closes
  // h0 (the CRC word) is compared against the CRC of all words before it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_reg    <= FC_CRC32_PRESET;
      shadow_reg <= FC_CRC32_PRESET;
    end else if (sof_word) begin
      crc_reg    <= FC_CRC32_PRESET;
      shadow_reg <= FC_CRC32_PRESET;
    end else if (data_accept) begin
      shadow_reg <= crc_reg;
      crc_reg    <= crc_next;
    end
  end

  // A truncated frame has no CRC word, so its CRC result is meaningless.
  assign crc_bad = ~truncate & (h0_reg != ~shadow_reg);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    err_vec            = 3'b000;
    err_vec[ERR_CRC]   = crc_bad;
    err_vec[ERR_LEN]   = len_bad;
    err_vec[ERR_ABORT] = abort_now;
  end

  // Frame pipeline: a 2-deep hold buffer delays every word by two data words
  // so the CRC word can be recognised (and dropped) when the EOF arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_OUT_OF_FRAME;
      count_reg     <= '0;
      h1_reg        <= '0;
      h0_reg        <= '0;
      fill_reg      <= 2'd0;
      emitted_reg   <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      out_error_reg <= 3'b000;
    end else begin
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      out_error_reg <= 3'b000;

      if (data_accept) begin
        if (count_reg != CNT_SAT) count_reg <= count_reg + CNT_W'(1);
        h0_reg <= in_data;
        h1_reg <= h0_reg;
        if (fill_reg == 2'd2) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= h1_reg;
          out_sop_reg   <= ~emitted_reg;
          emitted_reg   <= 1'b1;
        end else begin
          fill_reg <= fill_reg + 2'd1;
        end
      end

      if (close_frame) begin
        state_reg <= S_OUT_OF_FRAME;
        if (!short_frame) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= h1_reg;
          out_sop_reg   <= ~emitted_reg;
          out_eop_reg   <= 1'b1;
          out_error_reg <= err_vec;
        end
      end

      // Placed after the close so a truncating SOF reopens the frame.
      if (sof_word) begin
        state_reg   <= S_IN_FRAME;
        count_reg   <= '0;
        fill_reg    <= 2'd0;
        emitted_reg <= 1'b0;
      end
    end
  end

  // Statistics: one counter per closed frame, priority abort > length > CRC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt_reg  <= '0;
      len_cnt_reg   <= '0;
      abort_cnt_reg <= '0;
`ifdef FC_RX_FRAME_CHECK_CRC_EN
      crc_cnt_reg   <= '0;
`endif
    end else if (close_frame) begin
      if (abort_now)    abort_cnt_reg <= abort_cnt_reg + 32'd1;
      else if (len_bad) len_cnt_reg   <= len_cnt_reg + 32'd1;
`ifdef FC_RX_FRAME_CHECK_CRC_EN
      else if (crc_bad) crc_cnt_reg   <= crc_cnt_reg + 32'd1;
`endif
      else              good_cnt_reg  <= good_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= '0;
    end else if (mm_read) begin
      case (mm_address)
        STAT_ADDR_GOOD:    readdata_reg <= good_cnt_reg;
`ifdef FC_RX_FRAME_CHECK_CRC_EN
        STAT_ADDR_CRC_ERR: readdata_reg <= crc_cnt_reg;
`else
        STAT_ADDR_CRC_ERR: readdata_reg <= 32'd0;
`endif
        STAT_ADDR_LEN_ERR: readdata_reg <= len_cnt_reg;
        STAT_ADDR_ABORTED: readdata_reg <= abort_cnt_reg;
        STAT_ADDR_STATE:   readdata_reg <= {31'd0, state_reg};
        default:           readdata_reg <= 32'hFFFF_FFFF;
      endcase
    end
  end

  assign out_data          = out_data_reg;
  assign out_valid         = out_valid_reg;
  assign out_startofpacket = out_sop_reg;
  assign out_endofpacket   = out_eop_reg;
  assign out_error         = out_error_reg;
  assign out_empty         = 2'b00;
  assign mm_readdata       = readdata_reg;

endmodule

// File: tb/tb_fc_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_fc_rx_frame_checker.sv -- scoreboard bench for fc_rx_frame_checker.
// Frames are described as lists of words; the expected packet, error vector,
// emission cycle and statistics are derived from frame-level rules and a
// table-driven CRC-32, then checked by an independent output monitor.
// -----------------------------------------------------------------------------
module tb_fc_rx_frame_checker;

  localparam logic [31:0] SOFI3 = 32'hBCB5_5656;
  localparam logic [31:0] SOFN3 = 32'hBCB5_3636;
  localparam logic [31:0] EOFN  = 32'hBC95_D5D5;
  localparam logic [31:0] EOFA  = 32'hBC95_F5F5;
`ifdef FC_RX_FRAME_CHECK_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef logic [31:0] wq_t[$];
  typedef struct { logic [31:0] data; bit sop; bit eop; logic [2:0] err; int trig; } exp_t;
  typedef struct { logic [31:0] d; bit s; bit e; } w_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_startofpacket = 1'b0, in_endofpacket = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, out_startofpacket, out_endofpacket;
  logic [1:0]  out_empty;
  logic [2:0]  out_error;
  logic [2:0]  mm_address = '0;
  logic        mm_read = 1'b0;
  logic [31:0] mm_readdata;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fc_rx_frame_checker dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_data(out_data), .out_valid(out_valid),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_empty(out_empty), .out_error(out_error),
    .mm_address(mm_address), .mm_read(mm_read), .mm_readdata(mm_readdata)
  );

  int          checks = 0, errors = 0;
  exp_t        exp_q[$];
  int          stamp[int];
  int          word_idx = 0;
  int          m_good = 0, m_crc = 0, m_len = 0, m_abort = 0;
  logic [31:0] crc_tbl[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every presented word must be the next expected one, on time.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_sop", 32'(out_startofpacket), 32'(e.sop));
        chk("out_eop", 32'(out_endofpacket), 32'(e.eop));
        chk("out_error", 32'(out_error), 32'(e.err));
        chk("out_empty", 32'(out_empty), 32'd0);
        chk("latency", cyc, stamp[e.trig]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [31:0] ref_crc(input wq_t q, input int n);
    logic [31:0] c;
    logic [7:0]  by;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int b = 3; b >= 0; b--) begin
        by = q[i][b*8 +: 8];
        c  = (c >> 8) ^ crc_tbl[c[7:0] ^ by];
      end
    return c;
  endfunction

  // n random words followed by their correct CRC word.
  function automatic wq_t mk_frame(input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back($urandom);
    q.push_back(~ref_crc(q, n));
    return q;
  endfunction

  task automatic drive_word(input logic [31:0] d, input bit s, input bit e,
                            input bit gaps, input bit rd);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data = $urandom;
        in_startofpacket = 1'($urandom_range(0, 1));
        in_endofpacket = 1'($urandom_range(0, 1));
        mm_read = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_startofpacket = s;
    in_endofpacket = e;
    mm_address = 3'd0;
    mm_read = rd;
    stamp[word_idx] = cyc + 1;
    word_idx++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_startofpacket = 1'b0;
      in_endofpacket = 1'b0;
      mm_read = 1'b0;
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    in_valid = 1'b0;
    mm_address = a;
    mm_read = 1'b1;
    @(negedge clk);
    mm_read = 1'b0;
    d = mm_readdata;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v, req;
    for (int a = 7; a >= 0; a--) begin
      rd(3'(a), v);
      case (a)
        0: req = m_good;
        1: req = m_crc;
        2: req = m_len;
        3: req = m_abort;
        4: req = 32'd0;
        default: req = 32'hFFFF_FFFF;
      endcase
      chk($sformatf("%s_reg%0d", tag, a), v, req);
    end
    idle(2);
    chk($sformatf("%s_hold", tag), mm_readdata, m_good);
  endtask

  // end_kind: 0 = EOFn, 1 = EOFa, 2 = truncated (the next frame's SOF closes it)
  task automatic send_frame(input logic [31:0] sof, input wq_t dw, input int end_kind,
                            input bit gaps, input bit lone, input bit rd_on_end);
    w_t          lst[$];
    w_t          w;
    int          dpos[$];
    int          n, base, endpos;
    bit          len_b, ab_b, crc_b;
    logic [2:0]  ev;
    exp_t        e;
    logic [31:0] pre;
    n = dw.size();
    base = word_idx;
    w.d = sof; w.s = 1'b1; w.e = 1'b0;
    lst.push_back(w);
    for (int i = 0; i < n; i++) begin
      if (lone && $urandom_range(0, 7) == 0) begin
        w.d = ($urandom_range(0, 1) != 0) ? SOFI3 : EOFN; w.s = 1'b1; w.e = 1'b1;
        lst.push_back(w);
      end
      dpos.push_back(lst.size());
      w.d = dw[i]; w.s = 1'b0; w.e = 1'b0;
      lst.push_back(w);
    end
    if (end_kind != 2) begin
      w.d = (end_kind == 1) ? EOFA : EOFN; w.s = 1'b0; w.e = 1'b1;
      lst.push_back(w);
      endpos = lst.size() - 1;
    end else begin
      endpos = lst.size();
    end
    len_b = (n < 7) || (n > 535);
    ab_b  = (end_kind != 0);
    crc_b = 1'b0;
    if (CRC_EN && n >= 2 && end_kind != 2) crc_b = (dw[n-1] != ~ref_crc(dw, n - 1));
    ev  = {ab_b, len_b, crc_b};
    pre = m_good;
    if (ab_b) m_abort++;
    else if (len_b) m_len++;
    else if (crc_b) m_crc++;
    else m_good++;
    if (n >= 2) begin
      for (int j = 0; j <= n - 2; j++) begin
        e.data = dw[j];
        e.sop  = (j == 0);
        e.eop  = (j == n - 2);
        e.err  = e.eop ? ev : 3'b000;
        e.trig = base + ((j < n - 2) ? dpos[j+2] : endpos);
        exp_q.push_back(e);
      end
    end
    $display("frame words=%0d end=%0d gaps=%0d expected_error=%b", n, end_kind, gaps,
             (n >= 2) ? ev : 3'b000);
    for (int k = 0; k < lst.size(); k++)
      drive_word(lst[k].d, lst[k].s, lst[k].e, gaps, rd_on_end && (k == lst.size() - 1));
    if (rd_on_end) begin
      @(negedge clk);
      in_valid = 1'b0;
      mm_read = 1'b0;
      chk("read_vs_increment", mm_readdata, pre);
    end
  endtask

  initial begin
    wq_t         good, dw;
    logic [31:0] c, v;
    int          n, ek, prev_end;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tbl[i] = c;
    end

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sop", 32'(out_startofpacket), 32'd0);
    chk("rst_out_eop", 32'(out_endofpacket), 32'd0);
    chk("rst_out_error", 32'(out_error), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_readdata", mm_readdata, 32'd0);
    reset_n = 1'b1;
    idle(2);
    check_regs("reset");

    // Good frame: 6 header words, 4 fixed payload words, CRC
    for (int i = 0; i < 6; i++) good.push_back($urandom);
    good.push_back(32'h0001_0203);
    good.push_back(32'h0405_0607);
    good.push_back(32'h0809_0A0B);
    good.push_back(32'h0C0D_0E0F);
    good.push_back(~ref_crc(good, 10));
    send_frame(SOFI3, good, 0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_regs("good");

    // CRC corruption
    dw = good;
    dw[10] = dw[10] ^ 32'h1;
    send_frame(SOFI3, dw, 0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_regs("crc");

    // Length errors: 3 words + CRC, then a single word
    send_frame(SOFN3, mk_frame(3), 0, 1'b0, 1'b0, 1'b0);
    dw = {};
    dw.push_back($urandom);
    send_frame(SOFN3, dw, 0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_regs("len");

    // EOFa abort, then truncation followed by a clean frame
    send_frame(SOFI3, good, 1, 1'b0, 1'b0, 1'b0);
    send_frame(SOFI3, mk_frame(8), 2, 1'b0, 1'b0, 1'b0);
    send_frame(SOFN3, good, 0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_regs("abort");

    // Gaps and lone primitives inside an otherwise good frame
    send_frame(SOFI3, good, 0, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Length boundaries including count saturation
    send_frame(SOFI3, mk_frame(5), 0, 1'b0, 1'b0, 1'b0);
    send_frame(SOFI3, mk_frame(6), 0, 1'b0, 1'b0, 1'b0);
    send_frame(SOFI3, mk_frame(534), 0, 1'b0, 1'b0, 1'b0);
    send_frame(SOFI3, mk_frame(535), 0, 1'b0, 1'b0, 1'b0);
    send_frame(SOFI3, mk_frame(539), 0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_regs("bound");

    // Randomized frames with garbage between frames
    prev_end = 0;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 24);
      if (prev_end != 2 && $urandom_range(0, 3) == 0)
        drive_word($urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if (n == 0) dw = {};
      else dw = mk_frame(n - 1);
      if (n >= 1 && $urandom_range(0, 3) == 0) dw[n-1] = dw[n-1] ^ (32'h1 << $urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0: ek = 1;
        1: ek = 2;
        default: ek = 0;
      endcase
      if (n < 2) ek = 0;
      if (f == 39 && ek == 2) ek = 0;
      send_frame(($urandom_range(0, 1) != 0) ? SOFI3 : SOFN3, dw, ek,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if (ek != 2) idle($urandom_range(0, 2));
      prev_end = ek;
    end
    idle(4);
    check_regs("random");

    // Statistics read in the same cycle as the increment
    send_frame(SOFI3, good, 0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset mid-frame: two words already out, then silence and cleared counters
    dw = mk_frame(3);
    begin
      exp_t e;
      int   base;
      base = word_idx;
      for (int j = 0; j < 2; j++) begin
        e.data = dw[j]; e.sop = (j == 0); e.eop = 1'b0; e.err = 3'b000;
        e.trig = base + 3 + j;
        exp_q.push_back(e);
      end
      drive_word(SOFI3, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) drive_word(dw[j], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rd(3'd4, v);
    chk("state_in_frame", v, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
    end
    m_good = 0; m_crc = 0; m_len = 0; m_abort = 0;
    reset_n = 1'b1;
    idle(2);
    check_regs("midrst");
    send_frame(SOFI3, good, 0, 1'b1, 1'b0, 1'b0);
    idle(4);
    check_regs("final");

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
